// File: rtl/regfile_wb_sink.sv
// regfile_wb_sink: decode-side register file with a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards the landing writeback to reads.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rd_wb/_address/_data   writeback write port
//   issue_valid/_rd/_rd_address  decode issue and destination register
//   rs_/rt_ use, address, data   two combinational read ports
//   flush             squash in-flight writes (clears all pending counters)
//   stall             decode must hold; issue not accepted
//   issue_ready       destination pending counter not saturated
//   wb_err            sticky: writeback hit a register with nothing pending
//   reg_file          debug view, element i = register i+1
module regfile_wb_sink #(
  parameter int WIDTH          = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_COUNT      = 32,
  parameter int PEND_WIDTH     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_wb,
  input  logic [REG_ADDR_WIDTH-1:0] rd_address_wb,
  input  logic [WIDTH-1:0]          rd_data_wb,
  input  logic                      issue_valid,
  input  logic                      issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_address,
  input  logic                      rs_use,
  input  logic [REG_ADDR_WIDTH-1:0] rs_address,
  input  logic                      rt_use,
  input  logic [REG_ADDR_WIDTH-1:0] rt_address,
  input  logic                      flush,
  output logic [WIDTH-1:0]          rs_data,
  output logic [WIDTH-1:0]          rt_data,
  output logic                      stall,
  output logic                      issue_ready,
  output logic                      wb_err,
  output logic [WIDTH-1:0]          reg_file [REG_COUNT-1]
);

  localparam logic [PEND_WIDTH-1:0] PMAX = '1;

  logic [WIDTH-1:0]      regs     [REG_COUNT];
  logic [PEND_WIDTH-1:0] pend     [REG_COUNT];
  logic [PEND_WIDTH-1:0] pend_nxt [REG_COUNT];

  logic rs_ready;
  logic rt_ready;
  logic accept;
  logic wb_live;
  logic err_set;

  for (genvar i = 0; i < REG_COUNT - 1; i++) begin : g_dbg
    assign reg_file[i] = regs[i+1];
  end

`ifdef REGFILE_BYPASS_EN
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = rd_wb && rd_address_wb == rs_address
               && rs_address != '0;
  assign rt_hit = rd_wb && rd_address_wb == rt_address
               && rt_address != '0;

  assign rs_data = (rs_address == '0) ? '0 :
                   rs_hit ? rd_data_wb : regs[rs_address];
  assign rt_data = (rt_address == '0) ? '0 :
                   rt_hit ? rd_data_wb : regs[rt_address];

  // The last outstanding write landing now satisfies the consumer.
  assign rs_ready = pend[rs_address] == '0
    || (rs_hit && pend[rs_address] == PEND_WIDTH'(1));
  assign rt_ready = pend[rt_address] == '0
    || (rt_hit && pend[rt_address] == PEND_WIDTH'(1));
`else
  assign rs_data = (rs_address == '0) ? '0 : regs[rs_address];
  assign rt_data = (rt_address == '0) ? '0 : regs[rt_address];

  assign rs_ready = pend[rs_address] == '0;
  assign rt_ready = pend[rt_address] == '0;
`endif

  assign issue_ready = !(issue_rd && issue_rd_address != '0
                         && pend[issue_rd_address] == PMAX);

  assign stall = (rs_use && !rs_ready)
              || (rt_use && !rt_ready)
              || (issue_valid && !issue_ready);

  assign accept  = issue_valid && !stall && !flush;
  assign wb_live = rd_wb && rd_address_wb != '0;

  // A write racing its own issue is legitimate, not an orphan.
  assign err_set = wb_live && !flush
    && pend[rd_address_wb] == '0
    && !(accept && issue_rd && issue_rd_address == rd_address_wb);

  always_comb begin
    for (int a = 0; a < REG_COUNT; a++) begin
      pend_nxt[a] = pend[a];
    end
    pend_nxt[0] = '0;
    for (int a = 1; a < REG_COUNT; a++) begin
      if (flush) begin
        pend_nxt[a] = '0;
      end else begin
        unique case ({
          accept && issue_rd
            && issue_rd_address == REG_ADDR_WIDTH'(a),
          rd_wb && rd_address_wb == REG_ADDR_WIDTH'(a)
            && pend[a] != '0})
          2'b10:   pend_nxt[a] = pend[a] + PEND_WIDTH'(1);
          2'b01:   pend_nxt[a] = pend[a] - PEND_WIDTH'(1);
          default: pend_nxt[a] = pend[a];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < REG_COUNT; a++) begin
        regs[a] <= '0;
        pend[a] <= '0;
      end
      wb_err <= 1'b0;
    end else begin
      if (wb_live) begin
        regs[rd_address_wb] <= rd_data_wb;
      end
      for (int a = 0; a < REG_COUNT; a++) begin
        pend[a] <= pend_nxt[a];
      end
      if (err_set) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sink.sv
// tb_regfile_wb_sink: directed checks of regfile_wb_sink.
// Build with or without +define+REGFILE_BYPASS_EN.
module tb_regfile_wb_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_wb;
  logic [4:0]  rd_address_wb;
  logic [31:0] rd_data_wb;
  logic        issue_valid;
  logic        issue_rd;
  logic [4:0]  issue_rd_address;
  logic        rs_use;
  logic [4:0]  rs_address;
  logic        rt_use;
  logic [4:0]  rt_address;
  logic        flush;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        issue_ready;
  logic        wb_err;
  logic [31:0] reg_file [31];

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_wb_sink dut (
    .clk(clk), .rst(rst),
    .rd_wb(rd_wb), .rd_address_wb(rd_address_wb),
    .rd_data_wb(rd_data_wb),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_address(issue_rd_address),
    .rs_use(rs_use), .rs_address(rs_address),
    .rt_use(rt_use), .rt_address(rt_address),
    .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .issue_ready(issue_ready),
    .wb_err(wb_err), .reg_file(reg_file)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; rd_wb = 0; rd_address_wb = 0; rd_data_wb = 0;
    issue_valid = 0; issue_rd = 0; issue_rd_address = 0;
    rs_use = 0; rs_address = 0; rt_use = 0; rt_address = 0;
    flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1; issue_rd = 1; issue_rd_address = a;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    rd_wb = 1; rd_address_wb = a; rd_data_wb = d;
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    idle();
    #1;

    // reset state on every address
    for (int i = 0; i < 32; i++) begin
      rs_use = 1; rt_use = 1;
      rs_address = 5'(i); rt_address = 5'(31 - i);
      #1;
      check($sformatf("rst_rs%0d", i), rs_data, 32'h0);
      check($sformatf("rst_rt%0d", i), rt_data, 32'h0);
      check($sformatf("rst_stall%0d", i), {31'b0, stall}, 32'h0);
    end
    check("rst_ready", {31'b0, issue_ready}, 32'h1);
    check("rst_err", {31'b0, wb_err}, 32'h0);
    check("rst_dbg30", reg_file[30], 32'h0);
    idle();
    tick();

    // RAW hazard on r5
    issue(5'd5);
    #2 check("raw_issue_stall", {31'b0, stall}, 32'h0);
    tick();
    idle();
    rs_use = 1; rs_address = 5'd5;
    #2 check("raw_stall", {31'b0, stall}, 32'h1);
    tick();
    wb(5'd5, 32'hDEADBEEF);
    #2;
    check("raw_wb_stall", {31'b0, stall}, {31'b0, !BYP});
    check("raw_wb_data", rs_data,
          BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    rd_wb = 0;
    #2;
    check("raw_after_stall", {31'b0, stall}, 32'h0);
    check("raw_after_data", rs_data, 32'hDEADBEEF);
    check("raw_err", {31'b0, wb_err}, 32'h0);
    idle();
    tick();

    // r0 is constant zero and never pending
    wb(5'd0, 32'h00001234);
    issue(5'd0);
    rs_use = 1; rs_address = 5'd0;
    #2;
    check("r0_data_wb", rs_data, 32'h0);
    check("r0_ready", {31'b0, issue_ready}, 32'h1);
    tick();
    rd_wb = 0;
    for (int i = 0; i < 4; i++) begin
      #2 check($sformatf("r0_stall%0d", i),
               {31'b0, stall}, 32'h0);
      tick();
    end
    check("r0_data", rs_data, 32'h0);
    check("r0_err", {31'b0, wb_err}, 32'h0);
    idle();
    tick();

    // saturate r7 at three in-flight writes
    for (int i = 0; i < 3; i++) begin
      issue(5'd7);
      #2 check($sformatf("sat_acc%0d", i),
               {31'b0, stall}, 32'h0);
      tick();
    end
    issue(5'd7);
    #2;
    check("sat_ready", {31'b0, issue_ready}, 32'h0);
    check("sat_stall", {31'b0, stall}, 32'h1);
    tick();
    idle();
    wb(5'd7, 32'h0000006F);
    tick();
    idle();
    issue(5'd7);
    #2;
    check("sat_ready_again", {31'b0, issue_ready}, 32'h1);
    check("sat_acc_again", {31'b0, stall}, 32'h0);
    tick();
    // counter is back at 3: drain through rt
    idle();
    rt_use = 1; rt_address = 5'd7;
    wb(5'd7, 32'h00000070);
    #2 check("drain_stall3", {31'b0, stall}, 32'h1);
    tick();
    wb(5'd7, 32'h00000071);
    #2 check("drain_stall2", {31'b0, stall}, 32'h1);
    tick();
    wb(5'd7, 32'h00000072);
    #2;
    check("drain_stall1", {31'b0, stall}, {31'b0, !BYP});
    check("drain_data1", rt_data,
          BYP ? 32'h00000072 : 32'h00000071);
    tick();
    rd_wb = 0;
    #2;
    check("drain_stall0", {31'b0, stall}, 32'h0);
    check("drain_data0", rt_data, 32'h00000072);
    check("drain_err", {31'b0, wb_err}, 32'h0);
    idle();
    tick();

    // write racing its own issue is not an error
    issue(5'd10);
    wb(5'd10, 32'h0000AAAA);
    #2 check("race_stall", {31'b0, stall}, 32'h0);
    tick();
    idle();
    rs_use = 1; rs_address = 5'd10;
    #2;
    check("race_err", {31'b0, wb_err}, 32'h0);
    check("race_pend", {31'b0, stall}, 32'h1);
    check("race_data", rs_data, 32'h0000AAAA);
    wb(5'd10, 32'h0000BBBB);
    tick();
    idle();
    #2 check("race_clear_err", {31'b0, wb_err}, 32'h0);
    tick();

    // orphan writeback
    wb(5'd9, 32'hCAFEF00D);
    tick();
    idle();
    #2;
    check("spur_err", {31'b0, wb_err}, 32'h1);
    check("spur_dbg", reg_file[8], 32'hCAFEF00D);
    tick();
    tick();
    check("spur_sticky", {31'b0, wb_err}, 32'h1);
    rst = 1;
    tick();
    rst = 0;
    #2;
    check("spur_rst_err", {31'b0, wb_err}, 32'h0);
    check("spur_rst_dbg", reg_file[8], 32'h0);
    check("rst_dbg4", reg_file[4], 32'h0);
    tick();

    // flush clears r3 and discards the same-cycle issue
    issue(5'd3);
    tick();
    issue(5'd3);
    tick();
    rs_use = 1; rs_address = 5'd3;
    #2 check("fl_pend_stall", {31'b0, stall}, 32'h1);
    idle();
    issue(5'd3);
    flush = 1;
    wb(5'd3, 32'h00000033);
    tick();
    idle();
    rs_use = 1; rs_address = 5'd3;
    #2;
    check("fl_stall", {31'b0, stall}, 32'h0);
    check("fl_err", {31'b0, wb_err}, 32'h0);
    check("fl_wb_data", rs_data, 32'h00000033);
    wb(5'd3, 32'h00000034);
    tick();
    idle();
    #2;
    check("fl_pend_zero", {31'b0, wb_err}, 32'h1);
    check("fl_dbg", reg_file[2], 32'h00000034);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
